// File: rtl/fb_video_pkg.sv
// fb_video_pkg: shared pixel, timing-tap and scan-state types
// for the framebuffer scanout path.
package fb_video_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic win;
    } tap_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        RUN
    } scan_state_e;

    // MSB replication keeps full-scale 565 values at full-scale 888
    function automatic rgb888_t expand_565(rgb565_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[5:4]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/fb_scanout_timing.sv
// video_timing: free-running h/v counters with raw de/hs/vs/win
// terms, next-cycle window lookahead and a last-cycle-of-frame flag.
module video_timing #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic de_o,
    output logic hs_o,
    output logic vs_o,
    output logic win_o,
    output logic win_nxt_o,
    output logic last_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;

    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));
    assign last_o = h_last && v_last;

    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign de_o = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hs_o = (h_q >= HW'(H_ACTIVE + H_FP))
               && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_o = (v_q >= VW'(V_ACTIVE + V_FP))
               && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign win_o = (h_q < HW'(FB_WIDTH)) && (v_q < VW'(FB_HEIGHT));
    assign win_nxt_o = (h_d < HW'(FB_WIDTH)) && (v_d < VW'(FB_HEIGHT));

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: clk_pix-domain framebuffer consumer; pixel requests,
// latency-aligned sync/DE and RGB565 to RGB888 colour path.
module fb_scanout
    import fb_video_pkg::*;
#(
    parameter int          H_ACTIVE       = 640,
    parameter int          H_FP           = 16,
    parameter int          H_SYNC         = 96,
    parameter int          H_BP           = 48,
    parameter int          V_ACTIVE       = 480,
    parameter int          V_FP           = 10,
    parameter int          V_SYNC         = 2,
    parameter int          V_BP           = 33,
    parameter int          FB_WIDTH       = 320,
    parameter int          FB_HEIGHT      = 240,
    parameter logic        SYNC_POL       = 1'b0,
    parameter int          STREAM_LATENCY = 2,
    parameter logic [15:0] BORDER_COLOR   = 16'h0000
) (
    input  logic        clk_pix,
    input  logic        reset_n_i,
    input  logic        enable_i,
    output logic        frame_start_o,
    output logic        stream_ena_o,
    input  logic [15:0] stream_data_i,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_de_o,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o
);
    logic raw_de, raw_hs, raw_vs, raw_win;
    logic win_nxt, last;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT)
    ) u_timing (
        .clk_i    (clk_pix),
        .rst_ni   (reset_n_i),
        .de_o     (raw_de),
        .hs_o     (raw_hs),
        .vs_o     (raw_vs),
        .win_o    (raw_win),
        .win_nxt_o(win_nxt),
        .last_o   (last)
    );

    scan_state_e state_q, state_d;

    // state only moves on the last cycle of a frame, except arming from IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (enable_i) state_d = WAIT_FRAME;
            WAIT_FRAME: if (last) state_d = enable_i ? RUN : IDLE;
            RUN:        if (last && !enable_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    logic ena_q, ena_d;
    logic fs_q, fs_d;

    assign ena_d = win_nxt && (state_d == RUN);
    assign fs_d  = last && (state_d == RUN);

    tap_t                      tap_in;
    tap_t                      tail;
    tap_t [STREAM_LATENCY-1:0] dly_q, dly_d;

    assign tap_in = '{
        de:  raw_de,
        hs:  raw_hs,
        vs:  raw_vs,
        win: raw_win && (state_q == RUN)
    };

    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = tap_in;
        for (int i = 1; i < STREAM_LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign tail = dly_q[STREAM_LATENCY-1];

    rgb565_t pix;

    always_comb begin
        pix = '0;
        priority case (1'b1)
            tail.win: pix = stream_data_i;
            tail.de:  pix = BORDER_COLOR;
            default:  pix = '0;
        endcase
    end

    logic    de_q, hsync_q, vsync_q;
    rgb888_t rgb_q;

    always_ff @(posedge clk_pix or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            ena_q   <= 1'b0;
            fs_q    <= 1'b0;
            dly_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            fs_q    <= fs_d;
            dly_q   <= dly_d;
            de_q    <= tail.de;
            hsync_q <= tail.hs ? SYNC_POL : ~SYNC_POL;
            vsync_q <= tail.vs ? SYNC_POL : ~SYNC_POL;
            rgb_q   <= expand_565(pix);
        end
    end

    assign frame_start_o = fs_q;
    assign stream_ena_o  = ena_q;
    assign vga_de_o      = de_q;
    assign vga_hsync_o   = hsync_q;
    assign vga_vsync_o   = vsync_q;
    assign vga_r_o       = rgb_q.r;
    assign vga_g_o       = rgb_q.g;
    assign vga_b_o       = rgb_q.b;

endmodule
